// File: rtl/alu_8bit_if.sv
// Operand/result bundle between the issuing stage and the 8-bit ALU.
// The master drives operands and opcode; the slave (ALU) returns the registered result.
interface alu_8bit_if;
  logic        InValid;
  logic [2:0]  OpCode;
  logic [7:0]  InputA;
  logic [7:0]  InputB;
  logic [15:0] OutALU;
  logic        COut;
  logic        OutValid;

  modport master (
    output InValid, OpCode, InputA, InputB,
    input  OutALU, COut, OutValid
  );

  modport slave (
    input  InValid, OpCode, InputA, InputB,
    output OutALU, COut, OutValid
  );
endinterface

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: eight unsigned operations, 16-bit result plus carry/borrow,
// one cycle of latency, captures only when InValid is high.
module alu_8bit (
  input  logic       Clk,
  input  logic       RstN,
  alu_8bit_if.slave  bus
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpMul = 3'b010,
    OpShl = 3'b011,
    OpShr = 3'b100,
    OpAnd = 3'b101,
    OpOr  = 3'b110,
    OpXor = 3'b111
  } opCodeT;

  logic [8:0]  sumS;
  logic [8:0]  diffS;
  logic [15:0] resultS;
  logic        carryS;
  logic [15:0] outAluR;
  logic        cOutR;
  logic        outValidR;

  // Next result and flag, purely combinational from the current operands
  always_comb begin
    sumS    = {1'b0, bus.InputA} + {1'b0, bus.InputB};
    // Bit 8 of the 9-bit difference is set exactly when A < B
    diffS   = {1'b0, bus.InputA} - {1'b0, bus.InputB};
    resultS = 16'h0000;
    carryS  = 1'b0;
    case (opCodeT'(bus.OpCode))
      OpAdd: begin
        resultS = {7'b000_0000, sumS};
        carryS  = sumS[8];
      end
      OpSub: begin
        resultS = {8'h00, diffS[7:0]};
        carryS  = diffS[8];
      end
      OpMul:   resultS = {8'h00, bus.InputA} * {8'h00, bus.InputB};
      OpShl:   resultS = {8'h00, bus.InputA} << bus.InputB[3:0];
      OpShr:   resultS = {8'h00, bus.InputA} >> bus.InputB[3:0];
      OpAnd:   resultS = {8'h00, bus.InputA & bus.InputB};
      OpOr:    resultS = {8'h00, bus.InputA | bus.InputB};
      OpXor:   resultS = {8'h00, bus.InputA ^ bus.InputB};
      default: begin
        resultS = 16'h0000;
        carryS  = 1'b0;
      end
    endcase
  end

  // Output registers: load on InValid, otherwise hold data and drop OutValid
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      outAluR   <= 16'h0000;
      cOutR     <= 1'b0;
      outValidR <= 1'b0;
    end else if (bus.InValid) begin
      outAluR   <= resultS;
      cOutR     <= carryS;
      outValidR <= 1'b1;
    end else begin
      outValidR <= 1'b0;
    end
  end

  assign bus.OutALU   = outAluR;
  assign bus.COut     = cOutR;
  assign bus.OutValid = outValidR;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed cases from the test plan plus
// randomized operations checked against an arithmetic reference model.
module tb_alu_8bit;

  logic Clk;
  logic RstN;
  int   testCount;
  int   failCount;
  int   mdlR;
  int   mdlC;
  int   mdlV;

  alu_8bit_if bus ();

  alu_8bit dut (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input int obs, input int expVal);
    testCount++;
    if (obs != expVal) begin
      failCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expVal);
    end
  endtask

  // Reference behaviour written straight from the operation table
  function automatic void refModel(input int op, input int a, input int b,
                                   output int r, output int c);
    r = 0;
    c = 0;
    case (op)
      0: begin r = a + b; c = (r > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a * b;
      3: r = (a * (1 << (b % 16))) % 65536;
      4: r = a / (1 << (b % 16));
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      default: r = 0;
    endcase
  endfunction

  // Drive one cycle of stimulus on the falling edge, check just after the rising edge
  task automatic stepOp(input string tag, input logic v, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b);
    int r;
    int c;
    @(negedge Clk);
    bus.InValid = v;
    bus.OpCode  = op;
    bus.InputA  = a;
    bus.InputB  = b;
    @(posedge Clk);
    #1;
    if (v) begin
      refModel(int'(op), int'(a), int'(b), r, c);
      mdlR = r;
      mdlC = c;
      mdlV = 1;
    end else begin
      mdlV = 0;
    end
    checkVal({tag, ".res"}, int'(bus.OutALU), mdlR);
    checkVal({tag, ".cout"}, int'(bus.COut), mdlC);
    checkVal({tag, ".valid"}, int'(bus.OutValid), mdlV);
  endtask

  task automatic expectConst(input string tag, input int r, input int c);
    checkVal({tag, ".specRes"}, int'(bus.OutALU), r);
    checkVal({tag, ".specCout"}, int'(bus.COut), c);
  endtask

  task automatic expectCleared(input string tag);
    checkVal({tag, ".res"}, int'(bus.OutALU), 0);
    checkVal({tag, ".cout"}, int'(bus.COut), 0);
    checkVal({tag, ".valid"}, int'(bus.OutValid), 0);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    mdlR = 0;
    mdlC = 0;
    mdlV = 0;

    // Reset held with live random inputs
    RstN        = 1'b0;
    bus.InValid = 1'b1;
    bus.OpCode  = 3'($urandom_range(7, 0));
    bus.InputA  = 8'($urandom_range(255, 0));
    bus.InputB  = 8'($urandom_range(255, 0));
    #1;
    expectCleared("rstImmediate");
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      bus.OpCode = 3'($urandom_range(7, 0));
      bus.InputA = 8'($urandom_range(255, 0));
      bus.InputB = 8'($urandom_range(255, 0));
      @(posedge Clk);
      #1;
      expectCleared("rstHeld");
    end
    @(negedge Clk);
    RstN = 1'b1;

    // First capture right after release, then back-to-back directed sets
    stepOp("add45_38", 1'b1, 3'b000, 8'd45, 8'd38); expectConst("add45_38", 83, 0);
    stepOp("sub45_38", 1'b1, 3'b001, 8'd45, 8'd38); expectConst("sub45_38", 7, 0);
    stepOp("or45_38",  1'b1, 3'b110, 8'd45, 8'd38); expectConst("or45_38", 47, 0);
    stepOp("xor45_38", 1'b1, 3'b111, 8'd45, 8'd38); expectConst("xor45_38", 11, 0);
    stepOp("mul49_10", 1'b1, 3'b010, 8'd49, 8'd10); expectConst("mul49_10", 490, 0);
    stepOp("shl49_10", 1'b1, 3'b011, 8'd49, 8'd10); expectConst("shl49_10", 50176, 0);
    stepOp("shr49_10", 1'b1, 3'b100, 8'd49, 8'd10); expectConst("shr49_10", 0, 0);
    stepOp("and49_10", 1'b1, 3'b101, 8'd49, 8'd10); expectConst("and49_10", 0, 0);

    // Carry, borrow and width edges
    stepOp("add255_1",   1'b1, 3'b000, 8'd255, 8'd1);   expectConst("add255_1", 256, 1);
    stepOp("sub38_45",   1'b1, 3'b001, 8'd38, 8'd45);   expectConst("sub38_45", 249, 1);
    stepOp("mul255_255", 1'b1, 3'b010, 8'd255, 8'd255); expectConst("mul255_255", 65025, 0);
    stepOp("shl255_15",  1'b1, 3'b011, 8'd255, 8'd15);  expectConst("shl255_15", 32768, 0);
    stepOp("shl1_F4",    1'b1, 3'b011, 8'd1, 8'hF4);    expectConst("shl1_F4", 16, 0);

    // Hold: capture, then drop InValid while inputs change
    stepOp("holdCap",  1'b1, 3'b000, 8'd45, 8'd38);  expectConst("holdCap", 83, 0);
    stepOp("holdIdle", 1'b0, 3'b010, 8'd200, 8'd99); expectConst("holdIdle", 83, 0);
    stepOp("holdIdle2", 1'b0, 3'b001, 8'd3, 8'd250); expectConst("holdIdle2", 83, 0);

    // Async reset between edges while holding 490
    stepOp("preRst", 1'b1, 3'b010, 8'd49, 8'd10); expectConst("preRst", 490, 0);
    #3;
    RstN = 1'b0;
    #1;
    expectCleared("midRst");
    mdlR = 0;
    mdlC = 0;
    mdlV = 0;
    @(posedge Clk);
    #1;
    expectCleared("midRstEdge");
    @(negedge Clk);
    RstN = 1'b1;
    stepOp("postRst", 1'b1, 3'b010, 8'd49, 8'd10); expectConst("postRst", 490, 0);

    // Randomized traffic, mostly valid, against the reference model
    for (int i = 0; i < 300; i++) begin
      stepOp("rand", ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0,
             3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)),
             8'($urandom_range(255, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
